// File: rtl/gray_bcd_display.sv
// Gray-to-decimal 7-segment driver: Gray->binary capture, sequential double-dabble, scanned digit output.
// Optional leading-zero blanking when GRAY_BCD_DISPLAY_LZB_EN is defined.
module gray_bcd_display #(
  parameter int GRAY_WIDTH  = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int REFRESH_DIV = 27000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GRAY_WIDTH-1:0] gray_code,
  output logic [GRAY_WIDTH-1:0] binary_code,
  output logic [6:0]            display_code,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_W  = 4 * (NUM_DIGITS + 1);
  localparam int STEP_W = $clog2(GRAY_WIDTH + 1);
  localparam int CNT_W  = $clog2(REFRESH_DIV + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_UPDATE  = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
    logic [GRAY_WIDTH-1:0] b;
    b[GRAY_WIDTH-1] = g[GRAY_WIDTH-1];
    for (int k = GRAY_WIDTH - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < NUM_DIGITS + 1; k++)
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction

  logic [1:0]              state;
  logic                    init;
  logic [GRAY_WIDTH-1:0]   last_gray;
  logic [GRAY_WIDTH-1:0]   shift_bin;
  logic [BCD_W-1:0]        bcd;
  logic [STEP_W-1:0]       step;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic [CNT_W-1:0]        refresh_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [6:0]              seg_next;

  assign busy = (state == S_CONVERT) || (state == S_UPDATE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      init        <= 1'b0;
      last_gray   <= '0;
      binary_code <= '0;
      shift_bin   <= '0;
      bcd         <= '0;
      step        <= '0;
      disp_bcd    <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!init || gray_code != last_gray) begin
            binary_code <= gray2bin(gray_code);
            shift_bin   <= gray2bin(gray_code);
            last_gray   <= gray_code;
            init        <= 1'b1;
            bcd         <= '0;
            step        <= '0;
            state       <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          {bcd, shift_bin} <= {dabble(bcd), shift_bin} << 1;
          step             <= step + 1'b1;
          if (step == STEP_W'(GRAY_WIDTH - 1)) state <= S_UPDATE;
        end
        S_UPDATE: begin
          disp_bcd <= bcd[4*NUM_DIGITS-1:0];
          // Top nibble alone misses values that also overflow the accumulator.
          overflow <= (64'(binary_code) >= LIMIT) || (bcd[BCD_W-1 -: 4] != 4'd0);
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    seg_next = seg(disp_bcd[int'(scan_idx)*4 +: 4]);
`ifdef GRAY_BCD_DISPLAY_LZB_EN
    if (scan_idx != '0 && (disp_bcd >> (4 * int'(scan_idx))) == '0) seg_next = 7'h00;
`endif
    if (overflow) seg_next = 7'h40;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt  <= '0;
      scan_idx     <= '0;
      digit_sel    <= ~NUM_DIGITS'(1);
      display_code <= 7'h3F;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      digit_sel    <= ~(NUM_DIGITS'(1) << scan_idx);
      display_code <= seg_next;
    end
  end

endmodule

// File: tb/tb_gray_bcd_display.sv
// Self-checking bench: 3-digit and 2-digit instances share one Gray input, checked against an arithmetic model.
module tb_gray_bcd_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray_code;
  logic [7:0] bin3, bin2;
  logic [6:0] seg3, seg2;
  logic [2:0] sel3;
  logic [1:0] sel2;
  logic       busy3, busy2, ovf3, ovf2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gray_bcd_display #(.GRAY_WIDTH(8), .NUM_DIGITS(3), .REFRESH_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .gray_code(gray_code), .binary_code(bin3),
    .display_code(seg3), .digit_sel(sel3), .busy(busy3), .overflow(ovf3));

  gray_bcd_display #(.GRAY_WIDTH(8), .NUM_DIGITS(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .gray_code(gray_code), .binary_code(bin2),
    .display_code(seg2), .digit_sel(sel2), .busy(busy2), .overflow(ovf2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int p10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p *= 10;
    return p;
  endfunction

  function automatic int gray_to_int(input logic [7:0] g);
    int b = 0;
    for (int s = 0; s < 8; s++) b ^= int'(g) >> s;
    return b;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i, input int n);
    logic [6:0] tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (v >= p10(n)) return 7'h40;
`ifdef GRAY_BCD_DISPLAY_LZB_EN
    if (i > 0 && v < p10(i)) return 7'h00;
`endif
    return tab[(v / p10(i)) % 10];
  endfunction

  function automatic int cur_sel(input int n);
    return (n == 3) ? int'(sel3) : int'(sel2);
  endfunction

  task automatic check_disp(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      int want = ((1 << n) - 1) & ~(1 << i);
      while (cur_sel(n) != want && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("scan_found_n%0d_d%0d", n, i), 32'(t < 40), 32'd1);
      chk($sformatf("seg_n%0d_d%0d_v%0d", n, i, v),
          32'((n == 3) ? seg3 : seg2), 32'(exp_seg(v, i, n)));
    end
  endtask

  // Called at the negedge right after the new value was captured.
  task automatic finish_conv(input int v);
    int c = 0;
    chk("busy3_start", 32'(busy3), 32'd1);
    chk("busy2_start", 32'(busy2), 32'd1);
    chk("bin3", 32'(bin3), 32'(v));
    chk("bin2", 32'(bin2), 32'(v));
    while (busy3 && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk("busy_cycles", 32'(c), 32'd9);
    chk("busy2_end", 32'(busy2), 32'd0);
    chk("ovf3", 32'(ovf3), 32'(v >= 1000));
    chk("ovf2", 32'(ovf2), 32'(v >= 100));
    @(negedge clk);
    check_disp(3, v);
    check_disp(2, v);
  endtask

  task automatic convert(input logic [7:0] g);
    gray_code = g;
    @(negedge clk);
    finish_conv(gray_to_int(g));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy3"}, 32'(busy3), 32'd0);
    chk({tag, "_busy2"}, 32'(busy2), 32'd0);
    chk({tag, "_bin3"}, 32'(bin3), 32'd0);
    chk({tag, "_bin2"}, 32'(bin2), 32'd0);
    chk({tag, "_ovf3"}, 32'(ovf3), 32'd0);
    chk({tag, "_ovf2"}, 32'(ovf2), 32'd0);
    chk({tag, "_sel3"}, 32'(sel3), 32'h6);
    chk({tag, "_sel2"}, 32'(sel2), 32'h2);
    chk({tag, "_seg3"}, 32'(seg3), 32'h3F);
    chk({tag, "_seg2"}, 32'(seg2), 32'h3F);
  endtask

  initial begin
    logic [7:0] g;
    logic [2:0] prev;
    int t, ph, c;

    rst = 1'b1;
    gray_code = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_reset_busy", 32'(busy3), 32'd0);
    chk("post_reset_bin", 32'(bin3), 32'd0);

    // Scan order: each digit held 4 cycles, rotating 110 -> 101 -> 011.
    prev = sel3;
    t = 0;
    while (sel3 == prev && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("scan_edge_found", 32'(t < 10), 32'd1);
    ph = (sel3 == 3'b110) ? 0 : (sel3 == 3'b101) ? 1 : 2;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("scan_seq_%0d", k), 32'(sel3), 32'(3'b111 & ~(3'b001 << ((ph + k / 4) % 3))));
      @(negedge clk);
    end
    check_disp(3, 0);
    check_disp(2, 0);

    convert(8'h80);
    convert(8'h0D);
    convert(8'h56);
    convert(8'h6F);

    // Change arrives mid-conversion: first result completes, then only the final value converts.
    gray_code = 8'h0D;
    @(negedge clk);
    chk("mid_busy", 32'(busy3), 32'd1);
    repeat (3) @(negedge clk);
    gray_code = 8'h80;
    c = 0;
    while (busy3 && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk("mid_first_bin", 32'(bin3), 32'd9);
    @(negedge clk);
    finish_conv(255);

    // Reset during conversion, then automatic reconversion of the held input.
    gray_code = 8'h56;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy", 32'(busy3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    finish_conv(100);

    g = 8'h56;
    for (int r = 0; r < 20; r++) begin
      logic [7:0] nx;
      nx = 8'($urandom_range(0, 255));
      if (nx == g) nx = nx ^ 8'h01;
      g = nx;
      convert(g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
